// File: rtl/stream_demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
//   DROP_CNT_W  : width of the saturating dropped-word counter
//   demux_mode_e: routing mode decoded from the broadcast input
//   ch_free     : a slot can take a new word when it is empty or draining now
package stream_demux_pkg;

  localparam int DROP_CNT_W = 8;

  typedef enum logic {MODE_UNICAST, MODE_BCAST} demux_mode_e;

  function automatic logic ch_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-deep output holding register for a single demux channel.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : write data_i into the slot this cycle (only asserted when free_o)
//   data_i        : word to load
//   ready_i       : downstream ready for this channel
//   valid_o       : slot holds a word
//   data_o        : held word, stable while valid_o && !ready_i
//   free_o        : slot can accept a word this cycle (empty or draining)
// Handshake: a word leaves the slot on a rising edge where valid_o && ready_i;
// a load on that same edge replaces it and valid_o stays high.
module demux_out_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign free_o  = ch_free(valid_q, ready_i);
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N stream demultiplexer with unicast and broadcast routing.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   in_valid_i       : input word present
//   in_ready_o       : input word accepted when in_valid_i && in_ready_o
//   in_data_i        : payload
//   in_sel_i         : target channel for unicast
//   in_bcast_i       : send to every channel (in_sel_i ignored)
//   out_valid_o      : per-channel valid
//   out_ready_i      : per-channel ready
//   out_data_o       : channel k at [k*DATA_W +: DATA_W]
//   err_o            : one-cycle pulse after an out-of-range select is dropped
//   drop_cnt_o       : saturating count of dropped words
// Handshake: every transfer on either side happens on a rising edge where
// valid and ready are both 1. in_ready_o is combinational from the selected
// slots' free status, which includes their out_ready_i.
module stream_demux_1_to_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic [SEL_W-1:0]       in_sel_i,
  input  logic                   in_bcast_i,
  output logic [N_CH-1:0]        out_valid_o,
  input  logic [N_CH-1:0]        out_ready_i,
  output logic [N_CH*DATA_W-1:0] out_data_o,
  output logic                   err_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

  // N_CH always fits in SEL_W+1 bits, so the range check needs one extra bit.
  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  demux_mode_e           mode;
  logic                  sel_in_range;
  logic [N_CH-1:0]       sel_hit;
  logic [N_CH-1:0]       free;
  logic [N_CH-1:0]       load;
  logic                  accept;
  logic                  drop;
  logic                  err_q, err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign mode         = in_bcast_i ? MODE_BCAST : MODE_UNICAST;
  assign sel_in_range = {1'b0, in_sel_i} < N_CH_L;

  // One-hot decode of the targeted slots; all slots in broadcast mode.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_hit[k] = (mode == MODE_BCAST) ||
                   (sel_in_range && ({1'b0, in_sel_i} == k[SEL_W:0]));
    end
  end

  // Broadcast waits until every slot is free so it is never partial.
  // An out-of-range unicast is always taken so it can be dropped.
  always_comb begin
    in_ready_o = 1'b1;
    if (mode == MODE_BCAST) begin
      in_ready_o = &free;
    end else if (sel_in_range) begin
      in_ready_o = |(sel_hit & free);
    end
  end

  assign accept = in_valid_i && in_ready_o;
  assign load   = accept ? sel_hit : '0;
  assign drop   = accept && (mode == MODE_UNICAST) && !sel_in_range;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[k]),
      .data_i  (in_data_i),
      .ready_i (out_ready_i[k]),
      .valid_o (out_valid_o[k]),
      .data_o  (out_data_o[k*DATA_W +: DATA_W]),
      .free_o  (free[k])
    );
  end

  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Bench for stream_demux_1_to_n: an 8-channel and a 6-channel instance are
// driven with the same input stream; a slot-level reference model tracks
// each instance and every cycle is compared against it, plus directed checks.
module tb_stream_demux_1_to_n;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- shared stimulus ----------------
  logic       in_valid_i = 1'b0;
  logic [7:0] in_data_i  = '0;
  logic [2:0] in_sel_i   = '0;
  logic       in_bcast_i = 1'b0;
  logic [7:0] out_ready_i = '0;

  // 8-channel instance
  logic        a_in_ready;
  logic [7:0]  a_out_valid;
  logic [63:0] a_out_data;
  logic        a_err;
  logic [7:0]  a_drop_cnt;

  // 6-channel instance
  logic        b_in_ready;
  logic [5:0]  b_out_valid;
  logic [47:0] b_out_data;
  logic        b_err;
  logic [7:0]  b_drop_cnt;

  stream_demux_1_to_n #(.DATA_W(8), .N_CH(8)) dut8 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (a_in_ready),
    .in_data_i   (in_data_i),
    .in_sel_i    (in_sel_i),
    .in_bcast_i  (in_bcast_i),
    .out_valid_o (a_out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (a_out_data),
    .err_o       (a_err),
    .drop_cnt_o  (a_drop_cnt)
  );

  stream_demux_1_to_n #(.DATA_W(8), .N_CH(6)) dut6 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (b_in_ready),
    .in_data_i   (in_data_i),
    .in_sel_i    (in_sel_i),
    .in_bcast_i  (in_bcast_i),
    .out_valid_o (b_out_valid),
    .out_ready_i (out_ready_i[5:0]),
    .out_data_o  (b_out_data),
    .err_o       (b_err),
    .drop_cnt_o  (b_drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int   nch[2] = '{8, 6};
  bit   mv[2][8];
  logic [7:0] md[2][8];
  int   mcnt[2];
  bit   merr[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        mv[d][k] = 1'b0;
        md[d][k] = '0;
      end
      mcnt[d] = 0;
      merr[d] = 1'b0;
    end
  endfunction

  function automatic bit m_free(int d, int k);
    return !mv[d][k] || out_ready_i[k];
  endfunction

  function automatic bit m_ready(int d);
    bit all_free = 1'b1;
    for (int k = 0; k < nch[d]; k++) all_free = all_free && m_free(d, k);
    if (in_bcast_i) return all_free;
    if (int'(in_sel_i) < nch[d]) return m_free(d, int'(in_sel_i));
    return 1'b1;
  endfunction

  function automatic void model_step(int d);
    bit acc = in_valid_i && m_ready(d);
    for (int k = 0; k < nch[d]; k++)
      if (mv[d][k] && out_ready_i[k]) mv[d][k] = 1'b0;
    merr[d] = 1'b0;
    if (acc) begin
      if (in_bcast_i) begin
        for (int k = 0; k < nch[d]; k++) begin
          mv[d][k] = 1'b1;
          md[d][k] = in_data_i;
        end
      end else if (int'(in_sel_i) < nch[d]) begin
        mv[d][int'(in_sel_i)] = 1'b1;
        md[d][int'(in_sel_i)] = in_data_i;
      end else begin
        merr[d] = 1'b1;
        if (mcnt[d] < 255) mcnt[d]++;
      end
    end
  endfunction

  function automatic logic [7:0] ch_data(int d, int k);
    return (d == 0) ? a_out_data[k*8 +: 8] : b_out_data[k*8 +: 8];
  endfunction

  task automatic check_dut(input int d);
    logic [7:0] vexp = '0;
    for (int k = 0; k < nch[d]; k++) vexp[k] = mv[d][k];
    check($sformatf("d%0d_in_ready", d), 64'(d ? b_in_ready : a_in_ready), 64'(m_ready(d)));
    check($sformatf("d%0d_out_valid", d), 64'(d ? {2'b00, b_out_valid} : a_out_valid), 64'(vexp));
    check($sformatf("d%0d_err", d), 64'(d ? b_err : a_err), 64'(merr[d]));
    check($sformatf("d%0d_drop_cnt", d), 64'(d ? b_drop_cnt : a_drop_cnt), 64'(mcnt[d]));
    for (int k = 0; k < nch[d]; k++)
      if (mv[d][k]) check($sformatf("d%0d_ch%0d_data", d, k), 64'(ch_data(d, k)), 64'(md[d][k]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [2:0] sel, input logic [7:0] data,
                       input logic bc, input logic [7:0] rdy);
    in_valid_i  = v;
    in_sel_i    = sel;
    in_data_i   = data;
    in_bcast_i  = bc;
    out_ready_i = rdy;
  endtask

  // Called at a falling edge with inputs driven; compares, advances the model
  // over the next rising edge and returns at the following falling edge.
  task automatic cycle();
    #1;
    check_dut(0);
    check_dut(1);
    model_step(0);
    model_step(1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    repeat (2) @(negedge clk_i);
    // reset state
    check("rst_valid8", 64'(a_out_valid), 64'h0);
    check("rst_data8", a_out_data, 64'h0);
    check("rst_err8", 64'(a_err), 64'h0);
    check("rst_cnt8", 64'(a_drop_cnt), 64'h0);
    check("rst_valid6", 64'(b_out_valid), 64'h0);
    check("rst_ready8", 64'(a_in_ready), 64'h1);
    rst_ni = 1'b1;

    // first unicast after reset
    drive(1'b1, 3'd3, 8'hA5, 1'b0, 8'hFF);
    cycle();
    check("uni_valid", 64'(a_out_valid), 64'h08);
    check("uni_ch3", 64'(a_out_data[31:24]), 64'hA5);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    cycle();
    check("uni_drain", 64'(a_out_valid), 64'h00);

    // backpressure isolation on channel 2
    drive(1'b1, 3'd2, 8'h11, 1'b0, 8'hFB);
    cycle();
    drive(1'b1, 3'd2, 8'h22, 1'b0, 8'hFB);
    cycle();
    check("bp_stall_ready", 64'(a_in_ready), 64'h0);
    check("bp_hold_ch2", 64'(a_out_data[23:16]), 64'h11);
    drive(1'b1, 3'd5, 8'h33, 1'b0, 8'hFB);
    cycle();
    check("bp_ch5_valid", 64'(a_out_valid[5]), 64'h1);
    check("bp_ch5_data", 64'(a_out_data[47:40]), 64'h33);
    check("bp_hold_ch2b", 64'(a_out_data[23:16]), 64'h11);
    drive(1'b1, 3'd2, 8'h22, 1'b0, 8'hFF);
    cycle();
    check("bp_release_ch2", 64'(a_out_data[23:16]), 64'h22);

    // back-to-back stream to channel 7
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'd7, 8'(i), 1'b0, 8'hFF);
      exp_q.push_back(8'(i));
      cycle();
      check("b2b_valid7", 64'(a_out_valid[7]), 64'h1);
      check("b2b_ch7", 64'(a_out_data[63:56]), 64'(exp_q.pop_front()));
    end

    // broadcast blocked by an occupied, stalled slot 4
    drive(1'b1, 3'd4, 8'h44, 1'b0, 8'hEF);
    cycle();
    drive(1'b1, 3'd1, 8'h5A, 1'b1, 8'hEF);
    cycle();
    check("bc_stall_ready", 64'(a_in_ready), 64'h0);
    check("bc_no_load", 64'(a_out_valid), 64'h10);
    drive(1'b1, 3'd1, 8'h5A, 1'b1, 8'hFF);
    cycle();
    check("bc_all_valid", 64'(a_out_valid), 64'hFF);
    check("bc_all_data", a_out_data, 64'h5A5A5A5A5A5A5A5A);
    check("bc_all_valid6", 64'(b_out_valid), 64'h3F);

    // out-of-range select on the 6-channel instance
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd7, 8'($urandom), 1'b0, 8'hFF);
      cycle();
      check("oor_ready6", 64'(b_in_ready), 64'h1);
      check("oor_err6", 64'(b_err), 64'h1);
      check("oor_novalid6", 64'(b_out_valid), 64'h0);
    end
    check("oor_sat6", 64'(b_drop_cnt), 64'd255);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    cycle();
    check("oor_err_end6", 64'(b_err), 64'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 7) == 0), 8'($urandom));
      cycle();
    end

    // mid-operation asynchronous reset with slots 0 and 1 stalled
    drive(1'b1, 3'd0, 8'hC0, 1'b0, 8'hFC);
    cycle();
    drive(1'b1, 3'd1, 8'hC1, 1'b0, 8'hFC);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 8'hFC);
    cycle();
    check("mid_full", 64'(a_out_valid[1:0]), 64'h3);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check("mid_valid8", 64'(a_out_valid), 64'h0);
    check("mid_valid6", 64'(b_out_valid), 64'h0);
    check("mid_cnt8", 64'(a_drop_cnt), 64'h0);
    check("mid_cnt6", 64'(b_drop_cnt), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 3'd2, 8'h77, 1'b0, 8'h00);
    cycle();
    check("post_rst_accept", 64'(a_out_data[23:16]), 64'h77);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux_1_to_n.md
# stream_demux_1_to_n

Parametrised, registered 1-to-N stream demultiplexer with per-channel valid/ready handshake and a broadcast mode. It routes each accepted input word to one selected output channel, or to all channels at once, through a one-deep holding register per channel. It replaces the fixed combinational 1-to-8 demux wherever the downstream consumers can apply backpressure. It sits between a single producer, such as a decoder or arbiter output, and N independent consumer channels.

## Interface
Parameters:
- `DATA_W`, default 8: payload width in bits.
- `N_CH`, default 8: number of output channels, 2..64; need not be a power of two.
- `SEL_W`, default `$clog2(N_CH)`: select width. This is derived; do not override it.

Ports:
- `clk_i`  in  1: single clock; all logic is on its rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `in_valid_i`  in  1: input word present.
- `in_ready_o`  out  1: input word accepted this cycle when both `in_valid_i` and `in_ready_o` are 1.
- `in_data_i`  in  `DATA_W`: payload.
- `in_sel_i`  in  `SEL_W`: target channel (unicast).
- `in_bcast_i`  in  1: 1 sends the word to all N_CH channels; `in_sel_i` is ignored.
- `out_valid_o`  out  `N_CH`: per-channel valid.
- `out_ready_i`  in  `N_CH`: per-channel ready.
- `out_data_o`  out  `N_CH*DATA_W`: channel k occupies bits [k*DATA_W +: DATA_W].
- `err_o`  out  1: one-cycle pulse when an out-of-range select is dropped.
- `drop_cnt_o`  out  8: saturating count of dropped words.

## Operation
Per-channel slot:
- Each channel has one slot: a valid bit plus a `DATA_W` register.
- The slot is "free" when `!out_valid_o[k] || out_ready_i[k]`; a slot draining this cycle counts as free.

Handshake and acceptance:
- `in_ready_o` is combinational. It may depend on `in_valid_i`, `in_sel_i` and `in_bcast_i`, but must not create a loop with `out_ready_i` → `in_ready_o` → upstream valid.
- Unicast, sel < N_CH: `in_ready_o` = free[sel]. On accept, slot[sel] loads `in_data_i` and sets valid.
- Unicast, sel ≥ N_CH: `in_ready_o` = 1. On accept, the word is dropped, `err_o` pulses next cycle, and `drop_cnt_o` increments, saturating at 255. No slot changes.
- Broadcast: `in_ready_o` = AND of free[k] over all k. On accept, every slot loads the same data and sets valid. This is all-or-nothing; there is never a partial broadcast.
- When `in_valid_i` = 0, `in_ready_o` still reflects the current sel/bcast, but nothing is loaded.

Output side:
- A channel handshake completes when `out_valid_o[k] && out_ready_i[k]`. The slot then clears unless it is reloaded in the same cycle.
- Load and drain in the same cycle on the same channel: the new data is loaded and `out_valid_o[k]` stays 1.
- While `out_valid_o[k]` = 1 and `out_ready_i[k]` = 0, `out_data_o[k]` must remain stable.
- Channels are independent. Backpressure on channel j never blocks unicast traffic to channel k ≠ j.

## Timing
- Latency is 1 cycle: a word accepted at edge n shows `out_valid_o` high after edge n.
- Throughput is 1 word per cycle to any channel whose `out_ready_i` is held at 1.
- `err_o` is asserted for exactly the one cycle after the dropped accept.
- `drop_cnt_o` is updated on the same edge that `err_o` rises.
- Reset values: `out_valid_o` = 0, `out_data_o` = 0, `err_o` = 0, `drop_cnt_o` = 0.
- `in_ready_o` during reset follows the free logic, so it reads 1 for all selects.
- Reset asserted mid-operation clears all slots asynchronously and discards pending data with no handshake. The first accept is possible on the first rising edge after `rst_ni` deasserts.

## Structure
- Package `stream_demux_pkg` holds:
  - `localparam DROP_CNT_W = 8`
  - function `ch_free(valid, ready)`
  - `typedef enum logic {MODE_UNICAST, MODE_BCAST} demux_mode_e`, used internally from `in_bcast_i`.
- Sub-module `demux_out_slot #(DATA_W)`:
  - Ports: `clk_i`, `rst_ni`, `load_i`, `data_i`, `ready_i`, `valid_o`, `data_o`, `free_o`.
  - Instantiated `N_CH` times in a generate loop.
- Top level contains the select decode, the broadcast AND-reduction, and the drop/error logic.

## Test plan
- **Reset:** with `rst_ni` = 0, all outputs are 0. Deassert, then send unicast sel=3, data=8'hA5, with all readies at 1. The next cycle shows `out_valid_o` = 8'b0000_1000, channel 3 = A5, and then `out_valid_o` returns to 0.
- **Backpressure isolation:** `out_ready_i[2]` = 0. Send 8'h11 to channel 2, then 8'h22 to channel 2.
  - The second word stalls (`in_ready_o` = 0) and channel 2 holds 11.
  - Meanwhile 8'h33 to channel 5 is accepted and appears on channel 5.
  - Raise `out_ready_i[2]`: 22 appears the next cycle.
- **Back-to-back:** with ready=1, stream 0x00..0x0F to channel 7 on consecutive cycles. Channel 7 shows one word per cycle, in order, with no bubbles.
- **Broadcast:** `in_bcast_i` = 1, data=8'h5A, `out_ready_i` = 8'hFF except bit 4 = 0, with slot 4 occupied.
  - `in_ready_o` = 0 and no channel loads.
  - Release bit 4: all 8 channels show 5A in the same cycle.
- **Out of range:** with N_CH=6 and sel=7, send 300 words.
  - `in_ready_o` = 1 throughout, and each accept gives a one-cycle `err_o` pulse.
  - No `out_valid_o` rises, and `drop_cnt_o` saturates at 255.
- **Mid-operation reset:** with slots 0 and 1 full and stalled, pulse `rst_ni` low asynchronously between edges. `out_valid_o` drops to 0 immediately, and `drop_cnt_o` = 0.
